// File: rtl/tl_request_ctrl.sv
// tl_request_ctrl
//   Input conditioning in front of the traffic-light FSM. Both raw inputs are
//   brought into the clock domain with a 2-FF synchroniser and then debounced.
//   A rising edge of the debounced button becomes a one-cycle start request.
//   After each start pulse a lockout window runs, so two start pulses are
//   always at least LOCKOUT cycles apart.
//
// Ports
//   clk50m   in   system clock (50 MHz)
//   rst      in   asynchronous reset, active-high; every flop returns to 0
//   btn_i    in   raw pedestrian button, asynchronous and bouncing, 1 = pressed
//   night_i  in   raw night switch, asynchronous and bouncing
//   start    out  registered one-cycle request pulse to the traffic-light FSM
//   night    out  registered debounced night level
//   pending  out  registered; a request is stored until the lockout expires
//
// Parameters
//   CNT_WIDTH   width of the debounce counters
//   DEBOUNCE    consecutive stable cycles needed to accept a change (>= 1)
//   LOCK_WIDTH  width of the lockout counter
//   LOCKOUT     minimum spacing between start pulses, in cycles (>= 2)
//
// Configuration macro
//   TL_REQ_PENDING_EN  when defined, one request made during the lockout is
//                      stored and issued on expiry. When undefined, requests
//                      during the lockout are dropped and pending is tied to 0.

module tl_request_ctrl #(
  parameter int CNT_WIDTH  = 16,
  parameter int DEBOUNCE   = 50000,
  parameter int LOCK_WIDTH = 24,
  parameter int LOCKOUT    = 10000000
) (
  input  logic clk50m,
  input  logic rst,
  input  logic btn_i,
  input  logic night_i,
  output logic start,
  output logic night,
  output logic pending
);

  localparam logic [CNT_WIDTH-1:0]  DEB_LAST  = CNT_WIDTH'(DEBOUNCE - 1);
  localparam logic [LOCK_WIDTH-1:0] LOCK_LOAD = LOCK_WIDTH'(LOCKOUT - 1);

  typedef enum logic {
    READY = 1'b0,
    LOCK  = 1'b1
  } state_t;

  // Bit 0 carries the button, bit 1 the night switch.
  logic [1:0]           raw;
  logic [1:0]           sync1_reg;
  logic [1:0]           sync2_reg;
  logic [1:0]           stable_reg;
  logic [CNT_WIDTH-1:0] cnt_reg [2];
  logic [1:0]           accept;
  logic                 btn_prev_reg;
  logic                 btn_event;
  logic                 req_ok;

  state_t               state_reg;
  state_t               state_next;
  logic [LOCK_WIDTH-1:0] lock_reg;
  logic [LOCK_WIDTH-1:0] lock_next;
  logic                 start_reg;
  logic                 start_next;

  assign raw = {night_i, btn_i};

  // accept: the synchronised value has disagreed with the stable value for
  // DEBOUNCE consecutive cycles, so the stable register takes it this edge.
  for (genvar gi = 0; gi < 2; gi++) begin : g_accept
    assign accept[gi] = (sync2_reg[gi] != stable_reg[gi]) && (cnt_reg[gi] == DEB_LAST);
  end

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      sync1_reg    <= '0;
      sync2_reg    <= '0;
      stable_reg   <= '0;
      cnt_reg[0]   <= '0;
      cnt_reg[1]   <= '0;
      btn_prev_reg <= 1'b0;
    end else begin
      sync1_reg    <= raw;
      sync2_reg    <= sync1_reg;
      btn_prev_reg <= stable_reg[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2_reg[i] == stable_reg[i]) begin
          // Agreement (or a glitch that went away): restart the count.
          cnt_reg[i] <= '0;
        end else if (accept[i]) begin
          stable_reg[i] <= sync2_reg[i];
          cnt_reg[i]    <= '0;
        end else begin
          cnt_reg[i] <= cnt_reg[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign night     = stable_reg[1];
  // Only a press (rising edge of the debounced button) is a request.
  assign btn_event = stable_reg[0] & ~btn_prev_reg;
  assign req_ok    = btn_event & ~stable_reg[1];

`ifdef TL_REQ_PENDING_EN
  logic pend_reg;
  logic pend_next;
  logic night_rise;
  logic issue;

  // Debounced night is about to rise: any stored request is discarded now.
  assign night_rise = accept[1] & sync2_reg[1];
  // A request arriving on the expiry cycle itself is treated as pending and
  // issued by the same decision, giving exactly one pulse.
  assign issue      = (pend_reg | btn_event) & ~stable_reg[1] & ~night_rise;
`endif

  always_comb begin
    state_next = state_reg;
    lock_next  = lock_reg;
    start_next = 1'b0;
`ifdef TL_REQ_PENDING_EN
    pend_next  = pend_reg;
`endif
    case (state_reg)
      READY: begin
        if (req_ok) begin
          start_next = 1'b1;
          lock_next  = LOCK_LOAD;
          state_next = LOCK;
        end
      end
      LOCK: begin
        if (lock_reg == '0) begin
`ifdef TL_REQ_PENDING_EN
          if (issue) begin
            start_next = 1'b1;
            lock_next  = LOCK_LOAD;
          end else begin
            state_next = READY;
          end
          pend_next = 1'b0;
`else
          state_next = READY;
`endif
        end else begin
          lock_next = lock_reg - LOCK_WIDTH'(1);
`ifdef TL_REQ_PENDING_EN
          if (req_ok) begin
            pend_next = 1'b1;
          end
          if (night_rise) begin
            pend_next = 1'b0;
          end
`endif
        end
      end
      default: state_next = READY;
    endcase
  end

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      state_reg <= READY;
      lock_reg  <= '0;
      start_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      lock_reg  <= lock_next;
      start_reg <= start_next;
    end
  end

`ifdef TL_REQ_PENDING_EN
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      pend_reg <= 1'b0;
    end else begin
      pend_reg <= pend_next;
    end
  end

  assign pending = pend_reg;
`else
  assign pending = 1'b0;
`endif

  assign start = start_reg;

endmodule
